// File: rtl/lsu_arb_pkg.sv
// Shared types and address-map constants for the LSU arbiter.
//   state_e    : arbiter sequencing states
//   cmd_ctl_t  : control fields of the registered command
//   *_BASE/*_LIMIT : inclusive byte ranges of the decoded memory/IO map
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Owner encoding: 0 = m0 (core datapath), 1 = m1 (debug/loader).
  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  typedef struct packed {
    logic owner;
    logic wren;
    logic legal;
  } cmd_ctl_t;

  // Data memory, read/write.
  localparam logic [31:0] DMEM_BASE    = 32'h0000_2000;
  localparam logic [31:0] DMEM_LIMIT   = 32'h0000_3FFF;
  // Output peripherals (LEDR, LEDG, HEX, LCD), read/write.
  localparam logic [31:0] OUT_IO_BASE  = 32'h0000_7000;
  localparam logic [31:0] OUT_IO_LIMIT = 32'h0000_703F;
  // Input peripherals (SW, BTN), read only.
  localparam logic [31:0] IN_IO_BASE   = 32'h0000_7800;
  localparam logic [31:0] IN_IO_LIMIT  = 32'h0000_781F;

endpackage

// File: rtl/lsu_addr_check.sv
// Combinational legality check of one access against the memory/IO map.
//   i_addr    : byte address of the access
//   i_wren    : 1 = store, 0 = load
//   o_legal_c : 1 when the access may be forwarded to the LSU
module lsu_addr_check
  import lsu_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wren,
  output logic              o_legal_c
);

  localparam logic [ADDR_W-1:0] DMEM_LO   = ADDR_W'(DMEM_BASE);
  localparam logic [ADDR_W-1:0] DMEM_HI   = ADDR_W'(DMEM_LIMIT);
  localparam logic [ADDR_W-1:0] OUT_IO_LO = ADDR_W'(OUT_IO_BASE);
  localparam logic [ADDR_W-1:0] OUT_IO_HI = ADDR_W'(OUT_IO_LIMIT);
  localparam logic [ADDR_W-1:0] IN_IO_LO  = ADDR_W'(IN_IO_BASE);
  localparam logic [ADDR_W-1:0] IN_IO_HI  = ADDR_W'(IN_IO_LIMIT);

  logic in_dmem_c;
  logic in_out_io_c;
  logic in_in_io_c;

  assign in_dmem_c   = (i_addr >= DMEM_LO)   && (i_addr <= DMEM_HI);
  assign in_out_io_c = (i_addr >= OUT_IO_LO) && (i_addr <= OUT_IO_HI);
  assign in_in_io_c  = (i_addr >= IN_IO_LO)  && (i_addr <= IN_IO_HI);

  // Input peripherals are read-only: a store there is rejected.
  assign o_legal_c = in_dmem_c | in_out_io_c | (in_in_io_c & ~i_wren);

endmodule

// File: rtl/lsu_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of the shared LSU.
// One command at a time: IDLE (arbitrate, register) -> BUSY (drive LSU for one
// cycle) -> RESP (one-cycle ack/err to the owner) -> IDLE.
//   i_clk, i_rst_n                 : clock, async active-low reset
//   i_m{0,1}_req/wren/addr/wdata   : requester command, req held until ack
//   o_m{0,1}_ack/err/rdata         : completion pulse, reject flag, load data
//   o_lsu_wren/addr/st_data        : LSU command, non-zero only during BUSY
//   i_ld_data                      : LSU combinational read data
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,

  input  logic              i_m0_req,
  input  logic              i_m0_wren,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_ack,
  output logic              o_m0_err,
  output logic [DATA_W-1:0] o_m0_rdata,

  input  logic              i_m1_req,
  input  logic              i_m1_wren,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_ack,
  output logic              o_m1_err,
  output logic [DATA_W-1:0] o_m1_rdata,

  output logic              o_lsu_wren,
  output logic [ADDR_W-1:0] o_lsu_addr,
  output logic [DATA_W-1:0] o_lsu_st_data,
  input  logic [DATA_W-1:0] i_ld_data
);

  state_e            state_q, state_d;
  logic              last_m1_q, last_m1_d;
  cmd_ctl_t          cmd_q, cmd_d;

  logic              lsu_wren_q, lsu_wren_d;
  logic [ADDR_W-1:0] lsu_addr_q, lsu_addr_d;
  logic [DATA_W-1:0] lsu_st_data_q, lsu_st_data_d;

  logic              m0_ack_q, m0_ack_d;
  logic              m0_err_q, m0_err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic              m1_ack_q, m1_ack_d;
  logic              m1_err_q, m1_err_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic              any_req_c;
  logic              grant_m1_c;
  logic              sel_wren_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic              sel_legal_c;
  logic [DATA_W-1:0] ld_result_c;

  // Round-robin: on contention the requester not granted last time wins.
  assign any_req_c  = i_m0_req | i_m1_req;
  assign grant_m1_c = i_m1_req & (~i_m0_req | ~last_m1_q);

  assign sel_wren_c  = grant_m1_c ? i_m1_wren  : i_m0_wren;
  assign sel_addr_c  = grant_m1_c ? i_m1_addr  : i_m0_addr;
  assign sel_wdata_c = grant_m1_c ? i_m1_wdata : i_m0_wdata;

  lsu_addr_check #(
    .ADDR_W (ADDR_W)
  ) u_addr_check (
    .i_addr    (sel_addr_c),
    .i_wren    (sel_wren_c),
    .o_legal_c (sel_legal_c)
  );

  // Stores and rejected accesses return zero data.
  assign ld_result_c = (~cmd_q.wren & cmd_q.legal) ? i_ld_data : '0;

  // Next-state, command capture and response generation.
  always_comb begin
    state_d       = state_q;
    last_m1_d     = last_m1_q;
    cmd_d         = cmd_q;
    lsu_wren_d    = 1'b0;
    lsu_addr_d    = '0;
    lsu_st_data_d = '0;
    m0_ack_d      = 1'b0;
    m0_err_d      = 1'b0;
    m0_rdata_d    = m0_rdata_q;
    m1_ack_d      = 1'b0;
    m1_err_d      = 1'b0;
    m1_rdata_d    = m1_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (any_req_c) begin
          state_d       = BUSY;
          last_m1_d     = grant_m1_c;
          cmd_d.owner   = grant_m1_c ? OWNER_M1 : OWNER_M0;
          cmd_d.wren    = sel_wren_c;
          cmd_d.legal   = sel_legal_c;
          // LSU outputs are loaded here so they are valid for the whole BUSY cycle.
          lsu_wren_d    = sel_wren_c & sel_legal_c;
          lsu_addr_d    = sel_addr_c;
          lsu_st_data_d = sel_wdata_c;
        end
      end

      BUSY: begin
        state_d = RESP;
        if (cmd_q.owner == OWNER_M1) begin
          m1_ack_d   = 1'b1;
          m1_err_d   = ~cmd_q.legal;
          m1_rdata_d = ld_result_c;
        end else begin
          m0_ack_d   = 1'b1;
          m0_err_d   = ~cmd_q.legal;
          m0_rdata_d = ld_result_c;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight command silently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      last_m1_q     <= 1'b1;
      cmd_q         <= '0;
      lsu_wren_q    <= 1'b0;
      lsu_addr_q    <= '0;
      lsu_st_data_q <= '0;
      m0_ack_q      <= 1'b0;
      m0_err_q      <= 1'b0;
      m0_rdata_q    <= '0;
      m1_ack_q      <= 1'b0;
      m1_err_q      <= 1'b0;
      m1_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_m1_q     <= last_m1_d;
      cmd_q         <= cmd_d;
      lsu_wren_q    <= lsu_wren_d;
      lsu_addr_q    <= lsu_addr_d;
      lsu_st_data_q <= lsu_st_data_d;
      m0_ack_q      <= m0_ack_d;
      m0_err_q      <= m0_err_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_ack_q      <= m1_ack_d;
      m1_err_q      <= m1_err_d;
      m1_rdata_q    <= m1_rdata_d;
    end
  end

  assign o_lsu_wren    = lsu_wren_q;
  assign o_lsu_addr    = lsu_addr_q;
  assign o_lsu_st_data = lsu_st_data_q;
  assign o_m0_ack      = m0_ack_q;
  assign o_m0_err      = m0_err_q;
  assign o_m0_rdata    = m0_rdata_q;
  assign o_m1_ack      = m1_ack_q;
  assign o_m1_err      = m1_err_q;
  assign o_m1_rdata    = m1_rdata_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Self-checking bench for lsu_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized two-agent traffic, all checked against
// a transaction-level reference model with a behavioural LSU memory.
`timescale 1ns/1ps
module tb_lsu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_r   [2];
  logic        wren_r  [2];
  logic [31:0] addr_r  [2];
  logic [31:0] wdata_r [2];

  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        lsu_wren;
  logic [31:0] lsu_addr, lsu_st_data, ld_data;

  localparam logic [31:0] SW_VAL  = 32'h1234_5678;
  localparam logic [31:0] BTN_VAL = 32'h0000_00A5;

  logic [31:0] dmem [0:2047];
  logic [31:0] oio  [0:15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_m0_req     (req_r[0]),
    .i_m0_wren    (wren_r[0]),
    .i_m0_addr    (addr_r[0]),
    .i_m0_wdata   (wdata_r[0]),
    .o_m0_ack     (m0_ack),
    .o_m0_err     (m0_err),
    .o_m0_rdata   (m0_rdata),
    .i_m1_req     (req_r[1]),
    .i_m1_wren    (wren_r[1]),
    .i_m1_addr    (addr_r[1]),
    .i_m1_wdata   (wdata_r[1]),
    .o_m1_ack     (m1_ack),
    .o_m1_err     (m1_err),
    .o_m1_rdata   (m1_rdata),
    .o_lsu_wren   (lsu_wren),
    .o_lsu_addr   (lsu_addr),
    .o_lsu_st_data(lsu_st_data),
    .i_ld_data    (ld_data)
  );

  // Behavioural LSU: combinational read of memory and input peripherals.
  always_comb begin
    ld_data = 32'h0;
    if (lsu_addr >= 32'h2000 && lsu_addr <= 32'h3FFF)      ld_data = dmem[lsu_addr[12:2]];
    else if (lsu_addr >= 32'h7000 && lsu_addr <= 32'h703F) ld_data = oio[lsu_addr[5:2]];
    else if (lsu_addr >= 32'h7800 && lsu_addr <= 32'h780F) ld_data = SW_VAL;
    else if (lsu_addr >= 32'h7810 && lsu_addr <= 32'h781F) ld_data = BTN_VAL;
  end

  // ---------------- reference model ----------------
  int          errors = 0;
  int          checks = 0;
  int          cyc, free_cyc, t_grant;
  bit          t_valid, t_owner, t_wren, t_legal, last_m1;
  logic [31:0] t_addr, t_wdata;
  logic [31:0] exp_rdata [2];
  bit          obs_ack   [2];
  bit          obs_err   [2];
  logic [31:0] obs_rdata [2];
  int          ack_owner_q [$];
  int          ack0_cyc_q  [$];
  logic [31:0] seen_st_7010;

  function automatic bit legal_ref(input logic [31:0] a, input bit w);
    if (a >= 32'h2000 && a <= 32'h3FFF) return 1'b1;
    if (a >= 32'h7000 && a <= 32'h703F) return 1'b1;
    if (a >= 32'h7800 && a <= 32'h781F) return !w;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a >= 32'h2000 && a <= 32'h3FFF) return dmem[a[12:2]];
    if (a >= 32'h7000 && a <= 32'h703F) return oio[a[5:2]];
    if (a >= 32'h7800 && a <= 32'h780F) return SW_VAL;
    if (a >= 32'h7810 && a <= 32'h781F) return BTN_VAL;
    return 32'h0;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
    if (a >= 32'h2000 && a <= 32'h3FFF) dmem[a[12:2]] = d;
    else if (a >= 32'h7000 && a <= 32'h703F) oio[a[5:2]] = d;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; free_cyc = 0; t_valid = 0; t_grant = 0; last_m1 = 1'b1;
    exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
  endtask

  task automatic set_req(input int r, input bit q, input bit w, input logic [31:0] a,
                         input logic [31:0] d);
    req_r[r] = q; wren_r[r] = w; addr_r[r] = a; wdata_r[r] = d;
  endtask

  // One clock: advance model at the edge, compare all outputs at the falling edge.
  task automatic step();
    bit w;
    bit busy, resp;
    @(posedge clk);
    cyc++;
    if (t_valid && cyc == t_grant + 1) begin
      if (t_wren && t_legal) mem_write(t_addr, t_wdata);
      exp_rdata[t_owner] = (!t_wren && t_legal) ? mem_read(t_addr) : 32'h0;
    end
    if (cyc >= free_cyc && (req_r[0] || req_r[1])) begin
      w = (req_r[0] && req_r[1]) ? !last_m1 : req_r[1];
      t_owner = w; t_wren = wren_r[w]; t_addr = addr_r[w]; t_wdata = wdata_r[w];
      t_legal = legal_ref(t_addr, t_wren);
      t_valid = 1'b1; t_grant = cyc; free_cyc = cyc + 3; last_m1 = w;
    end
    @(negedge clk);
    busy = t_valid && cyc == t_grant;
    resp = t_valid && cyc == t_grant + 1;
    chk("lsu_wren", 32'(lsu_wren), 32'(busy && t_wren && t_legal));
    chk("lsu_addr", lsu_addr, busy ? t_addr : 32'h0);
    chk("lsu_st_data", lsu_st_data, busy ? t_wdata : 32'h0);
    chk("m0_ack", 32'(m0_ack), 32'(resp && !t_owner));
    chk("m1_ack", 32'(m1_ack), 32'(resp && t_owner));
    chk("m0_err", 32'(m0_err), 32'(resp && !t_owner && !t_legal));
    chk("m1_err", 32'(m1_err), 32'(resp && t_owner && !t_legal));
    chk("m0_rdata", m0_rdata, exp_rdata[0]);
    chk("m1_rdata", m1_rdata, exp_rdata[1]);
    obs_ack[0] = (m0_ack === 1'b1); obs_ack[1] = (m1_ack === 1'b1);
    obs_err[0] = m0_err; obs_err[1] = m1_err;
    obs_rdata[0] = m0_rdata; obs_rdata[1] = m1_rdata;
    if (obs_ack[0]) begin ack_owner_q.push_back(0); ack0_cyc_q.push_back(cyc); end
    if (obs_ack[1]) ack_owner_q.push_back(1);
    if (lsu_wren === 1'b1 && lsu_addr == 32'h7010) seen_st_7010 = lsu_st_data;
  endtask

  // Single transaction from one requester; returns the observed response.
  task automatic run_txn(input int r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         output bit done, output bit err, output logic [31:0] rdata);
    done = 0; err = 0; rdata = 32'h0;
    set_req(r, 1'b1, w, a, d);
    for (int i = 0; i < 8 && !done; i++) begin
      step();
      if (obs_ack[r]) begin done = 1; err = obs_err[r]; rdata = obs_rdata[r]; end
    end
    req_r[r] = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_timeout req=m%0d addr=%h got=no_ack exp=ack", r, a);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1: return 32'h2000 + (32'($urandom_range(0, 2047)) << 2);
      2:    return 32'h7000 + (32'($urandom_range(0, 15)) << 2);
      3:    return 32'h7800 + (32'($urandom_range(0, 7)) << 2);
      4: begin
        case ($urandom_range(0, 11))
          0: return 32'h1FFF;  1: return 32'h2000;  2: return 32'h3FFF;  3: return 32'h4000;
          4: return 32'h6FFF;  5: return 32'h7000;  6: return 32'h703F;  7: return 32'h7040;
          8: return 32'h77FF;  9: return 32'h7800;  10: return 32'h781F; default: return 32'h7820;
        endcase
      end
      default: return $urandom();
    endcase
  endfunction

  typedef struct {
    bit          owner;
    bit          wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [$];

  initial begin
    bit          done, err;
    logic [31:0] rd;

    for (int i = 0; i < 2048; i++) dmem[i] = 32'h0;
    for (int i = 0; i < 16; i++) oio[i] = 32'h0;
    for (int r = 0; r < 2; r++) set_req(r, 1'b0, 1'b0, 32'h0, 32'h0);
    seen_st_7010 = 32'h0;
    model_reset();
    rst_n = 1'b0;

    tbl.push_back('{0, 1, 32'h2000, 32'h0000_2909, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h2000, 32'h0,         0, 32'h0000_2909});
    tbl.push_back('{1, 0, 32'h7800, 32'h0,         0, 32'h1234_5678});
    tbl.push_back('{1, 1, 32'h7010, 32'h55AA_55AA, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h7010, 32'h0,         0, 32'h55AA_55AA});
    tbl.push_back('{1, 1, 32'h7800, 32'hDEAD_BEEF, 1, 32'h0});
    tbl.push_back('{1, 0, 32'h7800, 32'h0,         0, 32'h1234_5678});
    tbl.push_back('{1, 0, 32'h9000, 32'h0,         1, 32'h0});
    tbl.push_back('{0, 0, 32'h7810, 32'h0,         0, 32'h0000_00A5});
    tbl.push_back('{0, 1, 32'h3FFC, 32'h1122_3344, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h3FFC, 32'h0,         0, 32'h1122_3344});
    tbl.push_back('{0, 0, 32'h4000, 32'h0,         1, 32'h0});
    tbl.push_back('{0, 1, 32'h1FFC, 32'h0000_0077, 1, 32'h0});
    tbl.push_back('{0, 1, 32'h7030, 32'h0BAD_F00D, 0, 32'h0});
    tbl.push_back('{1, 0, 32'h7030, 32'h0,         0, 32'h0BAD_F00D});
    tbl.push_back('{1, 0, 32'h7040, 32'h0,         1, 32'h0});
    tbl.push_back('{1, 1, 32'h7810, 32'h0000_0001, 1, 32'h0});
    tbl.push_back('{1, 0, 32'h781C, 32'h0,         0, 32'h0000_00A5});
    tbl.push_back('{0, 0, 32'h7820, 32'h0,         1, 32'h0});

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lsu_wren", 32'(lsu_wren), 32'h0);
    chk("rst_lsu_addr", lsu_addr, 32'h0);
    chk("rst_lsu_st_data", lsu_st_data, 32'h0);
    chk("rst_m0_ack", 32'(m0_ack), 32'h0);
    chk("rst_m1_ack", 32'(m1_ack), 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    rst_n = 1'b1;
    model_reset();

    // Contention from reset: grants alternate starting with m0.
    set_req(0, 1'b1, 1'b0, 32'h2000, 32'h0);
    set_req(1, 1'b1, 1'b1, 32'h7010, 32'h55AA_55AA);
    ack_owner_q.delete();
    repeat (12) step();
    req_r[0] = 1'b0; req_r[1] = 1'b0;
    chk("contention_acks", 32'(ack_owner_q.size()), 32'd4);
    for (int i = 0; i < ack_owner_q.size() && i < 4; i++)
      chk("contention_order", 32'(ack_owner_q[i]), 32'(i % 2));
    chk("contention_m1_store", seen_st_7010, 32'h55AA_55AA);

    // Directed vectors.
    foreach (tbl[i]) begin
      run_txn(int'(tbl[i].owner), tbl[i].wren, tbl[i].addr, tbl[i].wdata, done, err, rd);
      if (done) begin
        chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
      end
    end

    // m0 holds req: one IDLE cycle between transactions, acks 3 cycles apart.
    ack0_cyc_q.delete();
    set_req(0, 1'b1, 1'b0, 32'h2000, 32'h0);
    repeat (10) step();
    req_r[0] = 1'b0;
    chk("b2b_acks", 32'(ack0_cyc_q.size()), 32'd3);
    for (int i = 1; i < ack0_cyc_q.size(); i++)
      chk("b2b_spacing", 32'(ack0_cyc_q[i] - ack0_cyc_q[i-1]), 32'd3);

    // Reset asserted mid-BUSY: LSU write drops at once, no ack ever follows.
    step();
    set_req(0, 1'b1, 1'b1, 32'h7030, 32'hCAFE_BABE);
    step();
    chk("abort_busy_wren", 32'(lsu_wren), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_wren_drop", 32'(lsu_wren), 32'h0);
    chk("abort_addr", lsu_addr, 32'h0);
    chk("abort_st_data", lsu_st_data, 32'h0);
    chk("abort_m0_rdata", m0_rdata, 32'h0);
    req_r[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_m0_ack", 32'(m0_ack), 32'h0);
      chk("abort_m0_err", 32'(m0_err), 32'h0);
    end
    rst_n = 1'b1;
    model_reset();
    run_txn(0, 1'b0, 32'h7030, 32'h0, done, err, rd);
    if (done) begin
      chk("post_rst_err", 32'(err), 32'h0);
      chk("post_rst_rdata", rd, 32'h0BAD_F00D);
    end

    // Randomized two-agent traffic; in-flight payloads are scrambled.
    for (int n = 0; n < 1500; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (obs_ack[r]) begin
          if ($urandom_range(0, 1) == 0) req_r[r] = 1'b0;
          else set_req(r, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
        end else if (!req_r[r]) begin
          if ($urandom_range(0, 9) < 4)
            set_req(r, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
        end else if (t_valid && int'(t_owner) == r && cyc == t_grant) begin
          set_req(r, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
